time_display_driver: RTL

Downstream consumer of the calendar counter chain: takes the binary sec/min/hour/day/mont/year values and drives an 8-digit multiplexed common-anode 7-segment display. Each display frame starts with a coherent snapshot of all six fields. A single shared serial double-dabble unit converts the snapshot to BCD. The BCD digits are then scanned out one digit at a time, with a page input selecting the time view or the date view.

---
 rtl/time_display_driver.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/time_display_driver.sv
// time_display_driver: snapshots the calendar fields once per display frame,
// converts them to BCD with one shared serial double-dabble unit, and scans
// the result onto an 8-digit multiplexed common-anode 7-segment display.
`timescale 1ns/1ps
module time_display_driver #(
    parameter int DIGIT_TICKS = 50000
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic [5:0]  sec,
    input  logic [5:0]  min,
    input  logic [4:0]  hour,
    input  logic [4:0]  day,
    input  logic [3:0]  mont,
    input  logic [12:0] year,
    input  logic        page,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);
    localparam int TW = $clog2(DIGIT_TICKS);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;

    // Bank layout: {year[15:0], mont[7:0], day[7:0], hour[7:0], min[7:0], sec[7:0]}
    logic [TW-1:0] tick_r;
    logic [2:0]    idx_r;
    logic          first_r;
    logic [5:0]    sec_r, min_r;
    logic [4:0]    hour_r, day_r;
    logic [3:0]    mont_r;
    logic [12:0]   year_r;
    logic          page_r;
    state_t        state_r;
    logic [2:0]    fld_r;
    logic [3:0]    cnt_r;
    logic [12:0]   bin_r;
    logic [15:0]   bcd_r;
    logic [55:0]   back_r;
    logic [55:0]   front_r;
    logic          valid_r;
    logic          tick_wrap_s;
    logic          frame_start_s;
    logic [12:0]   fld_val_s;
    logic [15:0]   bcd_adj_s;
    logic [3:0]    nib_s;
    logic          blank_s;
    logic          dp_on_s;

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign tick_wrap_s   = (tick_r == TW'(DIGIT_TICKS - 1));
    assign frame_start_s = first_r | (tick_wrap_s & (idx_r == 3'd7));
    assign bcd_adj_s     = dd_adjust(bcd_r);
    assign busy          = (state_r != IDLE);

    // Scan timebase: per-digit tick counter and digit index; first_r marks the post-reset frame.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            tick_r  <= '0;
            idx_r   <= 3'd0;
            first_r <= 1'b1;
        end else begin
            first_r <= 1'b0;
            if (tick_wrap_s) begin
                tick_r <= '0;
                idx_r  <= idx_r + 3'd1;
            end else begin
                tick_r <= tick_r + TW'(1);
            end
        end
    end

    // Coherent snapshot of all fields and the page select at each frame start.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            sec_r  <= 6'd0;
            min_r  <= 6'd0;
            hour_r <= 5'd0;
            day_r  <= 5'd0;
            mont_r <= 4'd0;
            year_r <= 13'd0;
            page_r <= 1'b0;
        end else if (frame_start_s) begin
            sec_r  <= sec;
            min_r  <= min;
            hour_r <= hour;
            day_r  <= day;
            mont_r <= mont;
            year_r <= year;
            page_r <= page;
        end
    end

    // Selects the snapshot field currently being converted, zero-extended to 13 bits.
    always_comb begin
        fld_val_s = 13'd0;
        case (fld_r)
            3'd0:    fld_val_s = {7'd0, sec_r};
            3'd1:    fld_val_s = {7'd0, min_r};
            3'd2:    fld_val_s = {8'd0, hour_r};
            3'd3:    fld_val_s = {8'd0, day_r};
            3'd4:    fld_val_s = {9'd0, mont_r};
            3'd5:    fld_val_s = year_r;
            default: fld_val_s = 13'd0;
        endcase
    end

    // Converter FSM: LOAD, 13 SHIFTs and STORE per field, then one COMMIT into the front bank.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_r <= IDLE;
            fld_r   <= 3'd0;
            cnt_r   <= 4'd0;
            bin_r   <= 13'd0;
            bcd_r   <= 16'd0;
            back_r  <= 56'd0;
            front_r <= 56'd0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (frame_start_s) begin
                        state_r <= LOAD;
                        fld_r   <= 3'd0;
                    end
                end
                LOAD: begin
                    bin_r   <= fld_val_s;
                    bcd_r   <= 16'd0;
                    cnt_r   <= 4'd0;
                    state_r <= SHIFT;
                end
                SHIFT: begin
                    bcd_r <= {bcd_adj_s[14:0], bin_r[12]};
                    bin_r <= {bin_r[11:0], 1'b0};
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'd12) begin
                        state_r <= STORE;
                    end
                end
                STORE: begin
                    case (fld_r)
                        3'd0:    back_r[7:0]   <= bcd_r[7:0];
                        3'd1:    back_r[15:8]  <= bcd_r[7:0];
                        3'd2:    back_r[23:16] <= bcd_r[7:0];
                        3'd3:    back_r[31:24] <= bcd_r[7:0];
                        3'd4:    back_r[39:32] <= bcd_r[7:0];
                        3'd5:    back_r[55:40] <= bcd_r;
                        default: back_r        <= back_r;
                    endcase
                    if (fld_r == 3'd5) begin
                        state_r <= COMMIT;
                    end else begin
                        fld_r   <= fld_r + 3'd1;
                        state_r <= LOAD;
                    end
                end
                COMMIT: begin
                    front_r <= back_r;
                    valid_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Chooses the BCD nibble, blanking and decimal point for the digit being scanned.
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
        dp_on_s = 1'b0;
        if (page_r) begin
            case (idx_r)
                3'd0:    nib_s = front_r[43:40];
                3'd1:    nib_s = front_r[47:44];
                3'd2:    nib_s = front_r[51:48];
                3'd3:    nib_s = front_r[55:52];
                3'd4:    begin nib_s = front_r[35:32]; dp_on_s = 1'b1; end
                3'd5:    nib_s = front_r[39:36];
                3'd6:    begin nib_s = front_r[27:24]; dp_on_s = 1'b1; end
                3'd7:    nib_s = front_r[31:28];
                default: blank_s = 1'b1;
            endcase
        end else begin
            case (idx_r)
                3'd0:    nib_s = front_r[3:0];
                3'd1:    nib_s = front_r[7:4];
                3'd2:    begin nib_s = front_r[11:8]; dp_on_s = 1'b1; end
                3'd3:    nib_s = front_r[15:12];
                3'd4:    begin nib_s = front_r[19:16]; dp_on_s = 1'b1; end
                3'd5:    nib_s = front_r[23:20];
                default: blank_s = 1'b1;
            endcase
        end
    end

    // Registered display drive; everything dark until the first front-bank commit.
    always_ff @(posedge clk_50MHz) begin
        if (rst || !valid_r) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'h01 << idx_r);
            seg <= blank_s ? 7'h7F : seg_code(nib_s);
            dp  <= ~dp_on_s;
        end
    end
endmodule
